// File: rtl/square_motion_ctrl.sv
// Per-frame erase / move / redraw of a square sprite, emitted as single-pixel plot requests.
// Velocity follows buttons with momentum, decay and saturation; the square bounces off screen edges.
module square_motion_ctrl #(
    parameter int         WIDTH       = 640,
    parameter int         HEIGHT      = 480,
    parameter int         SQUARE_SIZE = 4,
    parameter int         MAX_SPEED   = 7,
    parameter int         X_INIT      = 318,
    parameter int         Y_INIT      = 238,
    parameter logic [2:0] SQ_R        = 3'b111,
    parameter logic [2:0] SQ_G        = 3'b000,
    parameter logic [2:0] SQ_B        = 3'b000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_tick,
    input  logic              btn_left,
    input  logic              btn_right,
    input  logic              btn_up,
    input  logic              btn_down,
    output logic [9:0]        plot_x,
    output logic [8:0]        plot_y,
    output logic [2:0]        plot_r,
    output logic [2:0]        plot_g,
    output logic [2:0]        plot_b,
    output logic              plot_valid,
    input  logic              plot_ready,
    output logic              busy,
    output logic [9:0]        pos_x,
    output logic [8:0]        pos_y,
    output logic [1:0]        dbg_state,
    output logic signed [4:0] dbg_vx,
    output logic signed [4:0] dbg_vy
);

    localparam int                LG   = (SQUARE_SIZE > 1) ? $clog2(SQUARE_SIZE) : 1;
    localparam logic [LG-1:0]     LAST = LG'(SQUARE_SIZE - 1);
    localparam logic signed [4:0] VMAX = 5'(MAX_SPEED);
    localparam logic signed [11:0] XLIM = 12'(WIDTH - SQUARE_SIZE);
    localparam logic signed [11:0] YLIM = 12'(HEIGHT - SQUARE_SIZE);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ERASE  = 2'd1,
        S_UPDATE = 2'd2,
        S_DRAW   = 2'd3
    } state_t;

    state_t             r_state, w_state_n;
    logic [LG-1:0]      r_dx, r_dy;
    logic [9:0]         r_pos_x;
    logic [8:0]         r_pos_y;
    logic signed [4:0]  r_vx, r_vy;
    logic               w_last, w_xfer;
    logic signed [4:0]  w_vx_step, w_vy_step, w_vx_n, w_vy_n;
    logic signed [11:0] w_px_sum, w_py_sum;
    logic [9:0]         w_px_n;
    logic [8:0]         w_py_n;

    function automatic logic signed [4:0] vel_step(input logic signed [4:0] v,
                                                   input logic inc, input logic dec);
        logic signed [4:0] r;
        if (inc && !dec)      r = (v >= VMAX) ? VMAX : v + 5'sd1;
        else if (dec && !inc) r = (v <= -VMAX) ? -VMAX : v - 5'sd1;
        else if (v > 5'sd0)   r = v - 5'sd1;
        else if (v < 5'sd0)   r = v + 5'sd1;
        else                  r = v;
        return r;
    endfunction

    assign w_last    = (r_dx == LAST) && (r_dy == LAST);
    assign w_xfer    = plot_valid && plot_ready;
    assign pos_x     = r_pos_x;
    assign pos_y     = r_pos_y;
    assign dbg_state = r_state;
    assign dbg_vx    = r_vx;
    assign dbg_vy    = r_vy;

    // Next position is computed wide and signed so underflow past 0 is visible before clamping.
    always_comb begin
        w_vx_step = vel_step(r_vx, btn_right, btn_left);
        w_vy_step = vel_step(r_vy, btn_down, btn_up);
        w_px_sum  = $signed({2'b00, r_pos_x}) + $signed({{7{w_vx_step[4]}}, w_vx_step});
        w_py_sum  = $signed({3'b000, r_pos_y}) + $signed({{7{w_vy_step[4]}}, w_vy_step});
        w_px_n    = w_px_sum[9:0];
        w_vx_n    = w_vx_step;
        w_py_n    = w_py_sum[8:0];
        w_vy_n    = w_vy_step;
        if (w_px_sum < 12'sd0) begin
            w_px_n = 10'd0;
            w_vx_n = -w_vx_step;
        end else if (w_px_sum > XLIM) begin
            w_px_n = XLIM[9:0];
            w_vx_n = -w_vx_step;
        end
        if (w_py_sum < 12'sd0) begin
            w_py_n = 9'd0;
            w_vy_n = -w_vy_step;
        end else if (w_py_sum > YLIM) begin
            w_py_n = YLIM[8:0];
            w_vy_n = -w_vy_step;
        end
    end

    // Handshake: a beat transfers when plot_valid && plot_ready; while stalled the request
    // holds because coordinates derive only from position and the offset counter.
    always_comb begin
        w_state_n  = r_state;
        plot_valid = 1'b0;
        busy       = 1'b1;
        plot_x     = '0;
        plot_y     = '0;
        plot_r     = '0;
        plot_g     = '0;
        plot_b     = '0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (frame_tick) w_state_n = S_ERASE;
            end
            S_ERASE: begin
                plot_valid = 1'b1;
                plot_x     = r_pos_x + 10'(r_dx);
                plot_y     = r_pos_y + 9'(r_dy);
                if (plot_ready && w_last) w_state_n = S_UPDATE;
            end
            S_UPDATE: w_state_n = S_DRAW;
            S_DRAW: begin
                plot_valid = 1'b1;
                plot_x     = r_pos_x + 10'(r_dx);
                plot_y     = r_pos_y + 9'(r_dy);
                plot_r     = SQ_R;
                plot_g     = SQ_G;
                plot_b     = SQ_B;
                if (plot_ready && w_last) w_state_n = S_IDLE;
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_n;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dx    <= '0;
            r_dy    <= '0;
            r_pos_x <= 10'(X_INIT);
            r_pos_y <= 9'(Y_INIT);
            r_vx    <= '0;
            r_vy    <= '0;
        end else begin
            if (w_xfer) begin
                if (r_dx == LAST) begin
                    r_dx <= '0;
                    r_dy <= w_last ? '0 : r_dy + 1'b1;
                end else begin
                    r_dx <= r_dx + 1'b1;
                end
            end
            if (r_state == S_UPDATE) begin
                r_pos_x <= w_px_n;
                r_pos_y <= w_py_n;
                r_vx    <= w_vx_n;
                r_vy    <= w_vy_n;
            end
        end
    end

endmodule

// File: tb/tb_square_motion_ctrl.sv
// Bench for square_motion_ctrl: frame-level reference model checked every cycle,
// plus directed edge, stall, saturation and mid-frame reset scenarios.
module tb_square_motion_ctrl;

    localparam int S  = 4;
    localparam int NB = S * S;
    localparam int XL = 640 - S;
    localparam int YL = 480 - S;
    localparam int VM = 7;

    logic clk = 1'b0, reset = 1'b1, frame_tick = 1'b0, plot_ready = 1'b1;
    logic btn_left = 1'b0, btn_right = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
    logic [9:0] plot_x, pos_x;
    logic [8:0] plot_y, pos_y;
    logic [2:0] plot_r, plot_g, plot_b;
    logic plot_valid, busy;
    logic [1:0] dbg_state;
    logic signed [4:0] dbg_vx, dbg_vy;

    logic [9:0] e_plot_x, e_pos_x;
    logic [8:0] e_plot_y, e_pos_y;
    logic [2:0] e_r, e_g, e_b;
    logic e_valid, e_busy;
    logic [1:0] e_state;
    logic signed [4:0] e_vx, e_vy;

    int total = 0, bad = 0;
    int ready_mode = 0;
    bit count_en = 0;
    int xfers = 0;

    int m_px = 318, m_py = 238, m_vx = 0, m_vy = 0, m_n = 0;
    bit m_active = 0, m_upd = 0;

    always #5 clk = ~clk;

    square_motion_ctrl u_dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up), .btn_down(btn_down),
        .plot_x(plot_x), .plot_y(plot_y), .plot_r(plot_r), .plot_g(plot_g), .plot_b(plot_b),
        .plot_valid(plot_valid), .plot_ready(plot_ready), .busy(busy),
        .pos_x(pos_x), .pos_y(pos_y), .dbg_state(dbg_state), .dbg_vx(dbg_vx), .dbg_vy(dbg_vy)
    );

    square_motion_ctrl #(.X_INIT(634), .Y_INIT(1)) u_edge (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .btn_left(1'b0), .btn_right(1'b1), .btn_up(1'b1), .btn_down(1'b0),
        .plot_x(e_plot_x), .plot_y(e_plot_y), .plot_r(e_r), .plot_g(e_g), .plot_b(e_b),
        .plot_valid(e_valid), .plot_ready(plot_ready), .busy(e_busy),
        .pos_x(e_pos_x), .pos_y(e_pos_y), .dbg_state(e_state), .dbg_vx(e_vx), .dbg_vy(e_vy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, $signed(act), $signed(exp), $time);
        end
    endtask

    function automatic int step_v(int v, bit inc, bit dec);
        if (inc && !dec) return (v + 1 > VM) ? VM : v + 1;
        if (dec && !inc) return (v - 1 < -VM) ? -VM : v - 1;
        if (v > 0) return v - 1;
        if (v < 0) return v + 1;
        return 0;
    endfunction

    task automatic move(inout int p, inout int v, input int lim, input bit inc, input bit dec);
        v = step_v(v, inc, dec);
        p = p + v;
        if (p < 0) begin
            p = 0;
            v = -v;
        end else if (p > lim) begin
            p = lim;
            v = -v;
        end
    endtask

    // Reference model: a frame is 16 erase transfers, one update cycle, 16 draw transfers.
    always @(negedge clk) begin
        bit ev;
        int k;
        if (reset) begin
            chk("rst_valid", plot_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_plot_x", plot_x, 0);
            chk("rst_plot_y", plot_y, 0);
            chk("rst_colour", {plot_r, plot_g, plot_b}, 0);
            chk("rst_state", dbg_state, 0);
            chk("rst_pos_x", pos_x, 318);
            chk("rst_pos_y", pos_y, 238);
            chk("rst_vx", $signed(dbg_vx), 0);
            chk("rst_vy", $signed(dbg_vy), 0);
            m_px = 318; m_py = 238; m_vx = 0; m_vy = 0;
            m_n = 0; m_active = 0; m_upd = 0;
        end else begin
            ev = m_active && !m_upd;
            chk("busy", busy, m_active);
            chk("valid", plot_valid, ev);
            chk("pos_x", pos_x, m_px);
            chk("pos_y", pos_y, m_py);
            chk("vx", $signed(dbg_vx), m_vx);
            chk("vy", $signed(dbg_vy), m_vy);
            if (ev) begin
                k = m_n % NB;
                chk("plot_x", plot_x, m_px + k % S);
                chk("plot_y", plot_y, m_py + k / S);
                chk("plot_r", plot_r, (m_n >= NB) ? 7 : 0);
                chk("plot_gb", {plot_g, plot_b}, 0);
            end
            if (!m_active) begin
                if (frame_tick) begin
                    m_active = 1; m_n = 0; m_upd = 0;
                end
            end else if (m_upd) begin
                move(m_px, m_vx, XL, btn_right, btn_left);
                move(m_py, m_vy, YL, btn_down, btn_up);
                m_upd = 0;
            end else if (plot_ready) begin
                m_n++;
                if (m_n == NB) m_upd = 1;
                if (m_n == 2 * NB) m_active = 0;
            end
        end
    end

    always @(negedge clk) if (count_en && plot_valid && plot_ready) xfers++;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       plot_ready = 1'b1;
                1:       plot_ready = ~plot_ready;
                default: plot_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1 frame_tick = 1'b1;
        @(posedge clk);
        #1 frame_tick = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        @(negedge clk);
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_px[6] = '{319, 321, 324, 326, 327, 327};
        int exp_vx[6] = '{1, 2, 3, 2, 1, 0};
        int ex_px[3]  = '{635, 636, 635};
        int ex_vx[3]  = '{1, -2, -1};
        int ex_py[3]  = '{0, 0, 1};
        int ex_vy[3]  = '{-1, 2, 1};
        int exp_py[10] = '{239, 241, 244, 248, 253, 259, 266, 273, 280, 287};
        logic [3:0] bias;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Momentum with btn_right, timeline pins on the first frame, edge bounces on u_edge.
        btn_right = 1'b1;
        for (int f = 0; f < 6; f++) begin
            if (f == 3) btn_right = 1'b0;
            tick();
            if (f == 0) begin
                @(negedge clk);
                chk("c1_valid", plot_valid, 1);
                chk("c1_busy", busy, 1);
                chk("c1_xy", {plot_x, plot_y}, {10'd318, 9'd238});
                chk("c1_red", plot_r, 0);
                repeat (15) @(negedge clk);
                chk("c16_xy", {plot_x, plot_y}, {10'd321, 9'd241});
                @(negedge clk);
                chk("c17_valid", plot_valid, 0);
                chk("c17_busy", busy, 1);
                @(negedge clk);
                chk("c18_pos_x", pos_x, 319);
                chk("c18_xy", {plot_x, plot_y}, {10'd319, 9'd238});
                chk("c18_red", plot_r, 7);
                repeat (15) @(negedge clk);
                chk("c33_busy", busy, 1);
                @(negedge clk);
                chk("c34_busy", busy, 0);
            end else begin
                wait_idle(200);
            end
            chk("frame_pos_x", pos_x, exp_px[f]);
            chk("frame_vx", $signed(dbg_vx), exp_vx[f]);
            if (f < 3) begin
                chk("edge_pos_x", e_pos_x, ex_px[f]);
                chk("edge_vx", $signed(e_vx), ex_vx[f]);
                chk("edge_pos_y", e_pos_y, ex_py[f]);
                chk("edge_vy", $signed(e_vy), ex_vy[f]);
                chk("edge_idle", e_state, 0);
            end
        end

        // Vertical saturation at MAX_SPEED.
        btn_down = 1'b1;
        for (int f = 0; f < 10; f++) begin
            tick();
            wait_idle(200);
            chk("sat_vy", $signed(dbg_vy), (f < 6) ? f + 1 : 7);
            chk("sat_pos_y", pos_y, exp_py[f]);
        end
        btn_down = 1'b0;

        // Stalled handshake and an ignored tick mid-pass.
        ready_mode = 1;
        xfers = 0;
        count_en = 1;
        tick();
        repeat (8) @(posedge clk);
        tick();
        wait_idle(1000);
        repeat (5) @(negedge clk);
        chk("stall_busy_after", busy, 0);
        chk("stall_xfers", xfers, 32);
        count_en = 0;

        // Random buttons, ticks and backpressure, with direction bias blocks to reach the walls.
        ready_mode = 2;
        bias = 4'b0;
        for (int c = 0; c < 8000; c++) begin
            @(posedge clk);
            #1;
            if (c % 1000 == 0) bias = 4'($urandom_range(0, 15));
            btn_left   = bias[0] ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
            btn_right  = bias[1] ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
            btn_up     = bias[2] ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
            btn_down   = bias[3] ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
            frame_tick = ($urandom_range(0, 24) == 0);
        end
        frame_tick = 1'b0;
        {btn_left, btn_right, btn_up, btn_down} = 4'b0;
        ready_mode = 0;
        wait_idle(2000);

        // Reset during draw beat 7, then a clean pass.
        tick();
        repeat (23) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("midrst_valid", plot_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_pos", {pos_x, pos_y}, {10'd318, 9'd238});
        @(posedge clk);
        #1 reset = 1'b0;
        tick();
        @(negedge clk);
        chk("post_rst_valid", plot_valid, 1);
        chk("post_rst_xy", {plot_x, plot_y}, {10'd318, 9'd238});
        chk("post_rst_red", plot_r, 0);
        wait_idle(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
